jtag_display_tap: RTL and testbench
===================================

# jtag_display_tap

IEEE 1149.1-style TAP controller that lets an external JTAG probe read a 32-bit IDCODE and take over the seven-segment display. It drives the value/mode select of the display datapath (4-bit value, override flag) in place of the free-running counter. JTAG pins are oversampled in the `clk` domain, so there is no second clock domain. The block sits between the `ui_in`/`uio` pins and the display mux in the top level.

## Interface

Parameters:
- `IDCODE`, default 32'h1000_0B5F, value captured by the IDCODE instruction; bit 0 must be 1.
- `SYNC_STAGES`, default 2, synchronizer depth for `tck`, `tms` and `tdi`; legal range 2–3.

Ports:
- `clk` input 1: system clock; all state is in this domain.
- `rst_n` input 1: asynchronous, active-low reset.
- `tck` input 1: JTAG clock, asynchronous to `clk`.
- `tms` input 1: JTAG mode select, asynchronous.
- `tdi` input 1: JTAG data in, asynchronous.
- `tdo` output 1: JTAG data out, registered.
- `tdo_oe` output 1: output enable for `tdo`; 1 only while shifting.
- `disp_value` output 4: value for the display when overridden.
- `disp_override` output 1: 1 means the display shows `disp_value` instead of the counter.
- `tap_state` output 4: current TAP state code, for debug.

## Operation

Pin sampling:
- `tck`, `tms` and `tdi` each pass through `SYNC_STAGES` flops.
- A registered copy of synced `tck` gives one-cycle `tck_rise` and `tck_fall` strobes.
- `tms` and `tdi` are synchronized with equal delay, so they are sampled coherently with `tck_rise`.

TAP FSM:
- 16 standard states, advanced only on `tck_rise` using synced `tms`.
- Standard 1149.1 transitions apply.
- `tap_state` codes: TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauseDR=3, Ex2DR=0, UpdDR=5, SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauseIR=B, Ex2IR=8, UpdIR=D.

Instruction register (4 bits):
- Shift register: CapIR loads 4'b0001.
- In ShIR, each `tck_rise` shifts right with `tdi` entering the MSB.
- The active IR is loaded from the shift register in UpdIR.
- In TLR the active IR is forced to IDCODE (4'b0001).

Instructions:
- IDCODE=4'b0001: 32-bit DR; CapDR loads `IDCODE`.
- DISPLAY=4'b0010: 5-bit DR `{override, value[3:0]}`.
  - CapDR loads the current `{disp_override, disp_value}`.
  - UpdDR writes both outputs.
- BYPASS=4'b1111, and every other code: 1-bit DR; CapDR loads 0.

DR shift:
- Each DR shifts LSB-first on `tck_rise` in ShDR, with `tdi` entering the MSB.
- DRs are never written outside Capture and Shift.

Display register:
- Changes only in UpdDR while IR=DISPLAY, and in TLR.
- Entering or staying in TLR clears `disp_override`; `disp_value` is kept.

TDO:
- Changes only on `tck_fall`.
- In ShIR: `tdo` = IR shift LSB, `tdo_oe`=1.
- In ShDR: `tdo` = selected DR LSB, `tdo_oe`=1.
- In any other state: `tdo_oe`=0 and `tdo` holds its last value.

Reset values (`rst_n` low):
- `tap_state`=F, active IR=0001, all shift registers 0.
- `tdo`=0, `tdo_oe`=0, `disp_value`=0, `disp_override`=0.
- Synchronizer flops reset to 0.

Boundary conditions:
- Reset asserted mid-shift aborts the shift; there is no partial update.
- Five `tck_rise` with `tms`=1 reach TLR from any state.
- An unknown IR value behaves as BYPASS.

## Timing

- Pin edge to strobe: `SYNC_STAGES`+1 `clk` cycles.
- FSM, IR and DR registers update in the cycle after `tck_rise`.
- `tdo`/`tdo_oe` update in the cycle after `tck_fall`.
- `disp_*` update in the cycle after the `tck_rise` that leaves UpdDR's predecessor, i.e. the edge entering UpdDR; they are visible on the next `clk` edge.
- Constraint on `tck`: high and low phases must each be at least `SYNC_STAGES`+2 `clk` periods; slower is always legal.
- `tms`/`tdi` must be stable from the `tck` falling edge to the next rising edge plus `SYNC_STAGES`+1 `clk`.
- Simultaneous UpdDR write and TLR cannot occur (they are distinct states).

## Test plan

- Reset then 5×(`tms`=1) → `tap_state`=F, `tdo_oe`=0, `disp_override`=0; IR reads back 0001.
- From RTI, shift 32 bits of DR with IR defaulted to IDCODE → `tdo` stream LSB-first equals 32'h1000_0B5F; `tdo_oe`=1 only during ShDR.
- Load IR=0010, shift DR `tdi`=5'b1_1010 LSB-first, pass UpdDR → `disp_override`=1, `disp_value`=4'hA. Outputs are unchanged during Ex1DR; a second capture reads back 5'b11010.
- IR=1111 (and IR=0111), shift 8 bits 8'b1011_0011 → `tdo` shows 0 then the `tdi` bits delayed one `tck`.
- With override set, 5×(`tms`=1) → `disp_override`=0, `disp_value` still A.
- `rst_n` pulsed low mid-ShDR of DISPLAY → all outputs at reset values immediately; no display write.

Source files
------------

// File: rtl/jtag_display_tap.sv
// JTAG TAP with IDCODE and a DISPLAY data register that overrides the seven-segment value/mode.
// The JTAG pins are oversampled in the clk domain, so tck is treated as data here, not as a clock.
//
// state   | code | meaning
// TLR     | F    | test-logic-reset: IR forced to IDCODE, override cleared
// RTI     | C    | run-test/idle
// SEL_DR  | 7    | select DR scan
// CAP_DR  | 6    | capture selected DR
// SH_DR   | 2    | shift selected DR, tdo driven
// EX1_DR  | 1    | exit1 DR
// PAU_DR  | 3    | pause DR
// EX2_DR  | 0    | exit2 DR
// UPD_DR  | 5    | update DR (display written on entry)
// SEL_IR  | 4    | select IR scan
// CAP_IR  | E    | capture IR (loads 0001)
// SH_IR   | A    | shift IR, tdo driven
// EX1_IR  | 9    | exit1 IR
// PAU_IR  | B    | pause IR
// EX2_IR  | 8    | exit2 IR
// UPD_IR  | D    | update IR (active IR loaded on entry)
module jtag_display_tap #(
  parameter logic [31:0] IDCODE      = 32'h1000_0B5F,
  parameter int          SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tck,
  input  logic       tms,
  input  logic       tdi,
  output logic       tdo,
  output logic       tdo_oe,
  output logic [3:0] disp_value,
  output logic       disp_override,
  output logic [3:0] tap_state
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC, SEL_DR = 4'h7, CAP_DR = 4'h6,
    SH_DR  = 4'h2, EX1_DR = 4'h1, PAU_DR = 4'h3, EX2_DR = 4'h0,
    UPD_DR = 4'h5, SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR  = 4'hA,
    EX1_IR = 4'h9, PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  localparam logic [3:0] INS_IDCODE  = 4'b0001;
  localparam logic [3:0] INS_DISPLAY = 4'b0010;

  logic [SYNC_STAGES-1:0] r_tck_sync, r_tms_sync, r_tdi_sync;
  logic                   r_tck_d;
  logic                   w_tck, w_tms, w_tdi, w_tck_rise, w_tck_fall;

  tap_state_e  r_state, w_state_nxt;
  logic [3:0]  r_ir_sh, r_ir;
  logic [31:0] r_dr;
  logic        r_tdo, r_tdo_oe, r_disp_ovr;
  logic [3:0]  r_disp_val;

  // Equal-depth synchronizers keep tms/tdi aligned with the tck_rise strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tck_sync <= '0;
      r_tms_sync <= '0;
      r_tdi_sync <= '0;
      r_tck_d    <= 1'b0;
    end else begin
      r_tck_sync <= {r_tck_sync[SYNC_STAGES-2:0], tck};
      r_tms_sync <= {r_tms_sync[SYNC_STAGES-2:0], tms};
      r_tdi_sync <= {r_tdi_sync[SYNC_STAGES-2:0], tdi};
      r_tck_d    <= r_tck_sync[SYNC_STAGES-1];
    end
  end

  assign w_tck      = r_tck_sync[SYNC_STAGES-1];
  assign w_tms      = r_tms_sync[SYNC_STAGES-1];
  assign w_tdi      = r_tdi_sync[SYNC_STAGES-1];
  assign w_tck_rise = w_tck & ~r_tck_d;
  assign w_tck_fall = ~w_tck & r_tck_d;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      TLR:    w_state_nxt = w_tms ? TLR    : RTI;
      RTI:    w_state_nxt = w_tms ? SEL_DR : RTI;
      SEL_DR: w_state_nxt = w_tms ? SEL_IR : CAP_DR;
      CAP_DR: w_state_nxt = w_tms ? EX1_DR : SH_DR;
      SH_DR:  w_state_nxt = w_tms ? EX1_DR : SH_DR;
      EX1_DR: w_state_nxt = w_tms ? UPD_DR : PAU_DR;
      PAU_DR: w_state_nxt = w_tms ? EX2_DR : PAU_DR;
      EX2_DR: w_state_nxt = w_tms ? UPD_DR : SH_DR;
      UPD_DR: w_state_nxt = w_tms ? SEL_DR : RTI;
      SEL_IR: w_state_nxt = w_tms ? TLR    : CAP_IR;
      CAP_IR: w_state_nxt = w_tms ? EX1_IR : SH_IR;
      SH_IR:  w_state_nxt = w_tms ? EX1_IR : SH_IR;
      EX1_IR: w_state_nxt = w_tms ? UPD_IR : PAU_IR;
      PAU_IR: w_state_nxt = w_tms ? EX2_IR : PAU_IR;
      EX2_IR: w_state_nxt = w_tms ? UPD_IR : SH_IR;
      UPD_IR: w_state_nxt = w_tms ? SEL_DR : RTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= TLR;
      r_ir_sh    <= 4'b0000;
      r_ir       <= INS_IDCODE;
      r_dr       <= 32'd0;
      r_tdo      <= 1'b0;
      r_tdo_oe   <= 1'b0;
      r_disp_val <= 4'd0;
      r_disp_ovr <= 1'b0;
    end else begin
      if (w_tck_rise) begin
        r_state <= w_state_nxt;
        case (r_state)
          CAP_IR: r_ir_sh <= 4'b0001;
          SH_IR:  r_ir_sh <= {w_tdi, r_ir_sh[3:1]};
          CAP_DR: begin
            case (r_ir)
              INS_IDCODE:  r_dr <= IDCODE;
              INS_DISPLAY: r_dr <= {27'd0, r_disp_ovr, r_disp_val};
              default:     r_dr <= 32'd0;
            endcase
          end
          // One physical register serves all DRs; the tdi entry point sets the length.
          SH_DR: begin
            case (r_ir)
              INS_IDCODE:  r_dr      <= {w_tdi, r_dr[31:1]};
              INS_DISPLAY: r_dr[4:0] <= {w_tdi, r_dr[4:1]};
              default:     r_dr[0]   <= w_tdi;
            endcase
          end
          default: ;
        endcase
        if (w_state_nxt == UPD_IR) r_ir <= r_ir_sh;
        if (w_state_nxt == UPD_DR && r_ir == INS_DISPLAY) begin
          r_disp_ovr <= r_dr[4];
          r_disp_val <= r_dr[3:0];
        end
        if (w_state_nxt == TLR) begin
          r_ir       <= INS_IDCODE;
          r_disp_ovr <= 1'b0;
        end
      end
      if (w_tck_fall) begin
        if (r_state == SH_IR) begin
          r_tdo    <= r_ir_sh[0];
          r_tdo_oe <= 1'b1;
        end else if (r_state == SH_DR) begin
          r_tdo    <= r_dr[0];
          r_tdo_oe <= 1'b1;
        end else begin
          r_tdo_oe <= 1'b0;
        end
      end
    end
  end

  assign tdo           = r_tdo;
  assign tdo_oe        = r_tdo_oe;
  assign disp_value    = r_disp_val;
  assign disp_override = r_disp_ovr;
  assign tap_state     = r_state;

endmodule

// File: tb/tb_jtag_display_tap.sv
// Bench for jtag_display_tap: a TAP-level reference model (transition table, bit queues)
// is stepped alongside the DUT on every tck cycle; directed scans then randomized ones.
module tb_jtag_display_tap;

  localparam logic [31:0] IDC      = 32'h1000_0B5F;
  localparam int          TCK_HALF = 5;

  // Indexed by state code: {next when tms=1, next when tms=0}
  localparam logic [7:0] NXT_TBL [16] = '{
    8'h52, 8'h53, 8'h12, 8'h03, 8'hFE, 8'h7C, 8'h12, 8'h46,
    8'hDA, 8'hDB, 8'h9A, 8'h8B, 8'h7C, 8'h7C, 8'h9A, 8'hFC
  };

  logic       clk = 1'b0;
  logic       rst_n, tck, tms, tdi;
  logic       tdo, tdo_oe, disp_override;
  logic [3:0] disp_value, tap_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [3:0] m_state, m_ir, m_val;
  logic       m_ovr, m_tdo, m_oe;
  bit         m_irq[$];
  bit         m_drq[$];

  jtag_display_tap dut (
    .clk(clk), .rst_n(rst_n), .tck(tck), .tms(tms), .tdi(tdi),
    .tdo(tdo), .tdo_oe(tdo_oe), .disp_value(disp_value),
    .disp_override(disp_override), .tap_state(tap_state)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 4'hF; m_ir = 4'b0001; m_val = 4'd0; m_ovr = 1'b0;
    m_tdo = 1'b0; m_oe = 1'b0;
    m_irq = '{0, 0, 0, 0};
    m_drq.delete();
  endtask

  task automatic model_step(input logic tm, input logic ti);
    logic [7:0] e;
    logic [3:0] nx;
    e  = NXT_TBL[m_state];
    nx = tm ? e[7:4] : e[3:0];
    case (m_state)
      4'hE: m_irq = '{1, 0, 0, 0};
      4'hA: begin void'(m_irq.pop_front()); m_irq.push_back(ti); end
      4'h6: begin
        m_drq.delete();
        if (m_ir == 4'b0001) for (int i = 0; i < 32; i++) m_drq.push_back(IDC[i]);
        else if (m_ir == 4'b0010) begin
          for (int i = 0; i < 4; i++) m_drq.push_back(m_val[i]);
          m_drq.push_back(m_ovr);
        end else m_drq.push_back(1'b0);
      end
      4'h2: begin void'(m_drq.pop_front()); m_drq.push_back(ti); end
      default: ;
    endcase
    if (nx == 4'hD) m_ir = {m_irq[3], m_irq[2], m_irq[1], m_irq[0]};
    if (nx == 4'h5 && m_ir == 4'b0010) begin
      m_val = {m_drq[3], m_drq[2], m_drq[1], m_drq[0]};
      m_ovr = m_drq[4];
    end
    if (nx == 4'hF) begin m_ir = 4'b0001; m_ovr = 1'b0; end
    m_state = nx;
    if (nx == 4'hA) begin m_tdo = m_irq[0]; m_oe = 1'b1; end
    else if (nx == 4'h2) begin m_tdo = m_drq[0]; m_oe = 1'b1; end
    else m_oe = 1'b0;
  endtask

  // One full tck period; outputs sampled at the end of the low phase.
  task automatic step(input logic tm, input logic ti, output logic to);
    tms = tm; tdi = ti;
    repeat (TCK_HALF) @(negedge clk);
    tck = 1'b1;
    repeat (TCK_HALF) @(negedge clk);
    tck = 1'b0;
    repeat (TCK_HALF) @(negedge clk);
    model_step(tm, ti);
    check_val("tap_state", tap_state, m_state);
    check_val("tdo_oe", tdo_oe, m_oe);
    check_val("tdo", tdo, m_tdo);
    check_val("disp_value", disp_value, m_val);
    check_val("disp_override", disp_override, m_ovr);
    to = tdo;
  endtask

  task automatic to_tlr_rti();
    logic t;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  task automatic scan_ir(input logic [3:0] v, output logic [3:0] cap);
    logic t;
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    cap[0] = t;
    for (int i = 0; i < 4; i++) begin
      step(i == 3, v[i], t);
      if (i < 3) cap[i+1] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  task automatic scan_dr(input logic [39:0] d, input int n, output logic [39:0] cap);
    logic t;
    cap = '0;
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    cap[0] = t;
    for (int i = 0; i < n; i++) begin
      step(i == n - 1, d[i], t);
      if (i < n - 1) cap[i+1] = t;
    end
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
  endtask

  initial begin
    logic        t;
    logic [3:0]  irc, irv;
    logic [39:0] cap, dat;
    int          n;

    rst_n = 1'b0; tck = 1'b0; tms = 1'b1; tdi = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_val("rst_state", tap_state, 4'hF);
    check_val("rst_tdo", tdo, 1'b0);
    check_val("rst_oe", tdo_oe, 1'b0);
    check_val("rst_val", disp_value, 4'h0);
    check_val("rst_ovr", disp_override, 1'b0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    check_val("tlr_state", tap_state, 4'hF);
    step(1'b0, 1'b0, t);
    scan_ir(4'b0001, irc);
    check_val("ir_capture", irc, 4'b0001);

    scan_dr({8'd0, $urandom()}, 32, cap);
    check_val("idcode", cap[31:0], IDC);

    scan_ir(4'b0010, irc);
    scan_dr(40'h1A, 5, cap);
    check_val("disp_val_A", disp_value, 4'hA);
    check_val("disp_ovr_1", disp_override, 1'b1);
    scan_dr(40'h1A, 5, cap);
    check_val("disp_readback", cap[4:0], 5'b11010);

    irv = 4'b1111;
    for (int k = 0; k < 2; k++) begin
      scan_ir(irv, irc);
      dat = 40'hB3;
      scan_dr(dat, 8, cap);
      check_val("bypass_stream", cap[7:0], {dat[6:0], 1'b0});
      irv = 4'b0111;
    end

    scan_ir(4'b0010, irc);
    scan_dr(40'h1A, 5, cap);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, t);
    check_val("tlr_ovr_clr", disp_override, 1'b0);
    check_val("tlr_val_kept", disp_value, 4'hA);

    step(1'b0, 1'b0, t);
    scan_ir(4'b0010, irc);
    step(1'b1, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b0, t);
    step(1'b0, 1'b1, t);
    step(1'b0, 1'b1, t);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("midrst_state", tap_state, 4'hF);
    check_val("midrst_oe", tdo_oe, 1'b0);
    check_val("midrst_tdo", tdo, 1'b0);
    check_val("midrst_val", disp_value, 4'h0);
    check_val("midrst_ovr", disp_override, 1'b0);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    step(1'b1, 1'b0, t);
    step(1'b1, 1'b0, t);
    check_val("postrst_val", disp_value, 4'h0);

    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(5, 25);
      for (int s = 0; s < n; s++) step($urandom_range(0, 1), $urandom_range(0, 1), t);
      to_tlr_rti();
      case ($urandom_range(0, 3))
        0: irv = 4'b0001;
        1: irv = 4'b0010;
        2: irv = 4'b1111;
        default: irv = 4'($urandom_range(0, 15));
      endcase
      scan_ir(irv, irc);
      check_val("rand_ir_cap", irc, 4'b0001);
      for (int r = 0; r < 2; r++) begin
        dat = {8'($urandom()), 32'($urandom())};
        scan_dr(dat, $urandom_range(1, 36), cap);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
